framebuffer_dbuf: RTL and testbench
===================================

# framebuffer_dbuf

Double-buffered palette-index framebuffer. It sits between the rasteriser (write side, `wr_clk`) and the scan-out / palette lookup (read side, `rd_clk`). The writer draws into the back page while scan-out reads the front page. Page flips are requested by the writer and take effect only at the next vertical blank, so scan-out never tears. An optional fill engine clears the back page at one pixel per `wr_clk` cycle.

## Interface
Parameters:
- `RESOLUTION_X`, default 400: pixels per line.
- `RESOLUTION_Y`, default 300: lines per frame.
- `PALETTE_LENGTH`, default 256: palette entries. Pixel width `PW = $clog2(PALETTE_LENGTH)`.
- Derived: `XW = $clog2(RESOLUTION_X)`, `YW = $clog2(RESOLUTION_Y)`, `N = RESOLUTION_X*RESOLUTION_Y`, `AW = $clog2(N)`.

Ports:
- `wr_clk`, in, 1: write/control clock.
- `reset`, in, 1: synchronous to `wr_clk`, active-high. Must be held for ≥4 cycles of the slower clock.
- `rd_clk`, in, 1: scan-out clock.
- `re`, in, `1`: read enable (`rd_clk`).
- `pxl_x` / `pxl_y`, in, `XW`/`YW`: read coordinate (`rd_clk`).
- `vblank`, in, `1`: level-high during vertical blank (`rd_clk`).
- `palette_index`, out, `PW`: front-page pixel (`rd_clk`).
- `we`, in, `1`: write request (`wr_clk`).
- `wr_ready`, out, `1`: write accepted when `we && wr_ready`.
- `wr_pxl_x` / `wr_pxl_y`, in, `XW`/`YW`: write coordinate.
- `wr_palette_index`, in, `PW`: write data.
- `flip_req`, in, `1`: one-cycle request to swap pages.
- `flip_done`, out, `1`: one-cycle pulse when the swap is applied.
- `clear_start`, in, `1`: one-cycle request to fill the back page.
- `fill_index`, in, `PW`: fill value, sampled on `clear_start`.
- `clear_busy`, out, `1`: high while the fill is in progress.
- `front_page`, out, `1`: current front page (`wr_clk` domain).

## Operation
- Memory is `2*N` entries of `PW` bits, addressed `{page, RESOLUTION_X*y + x}`. Contents are not reset.
- The back page is `~front_page`. All writes and fills target the back page only.
- The FSM is on `wr_clk`, states IDLE, CLEAR, FLIP_WAIT. Reset state is IDLE.
- `wr_ready = (state == IDLE)`. In IDLE, `we` writes the back page.
- A write with `wr_pxl_x >= RESOLUTION_X` or `wr_pxl_y >= RESOLUTION_Y` is accepted and dropped.
- IDLE + `clear_start`:
  - Go to CLEAR and latch `fill_index`.
  - The counter runs 0..N-1, writing one address per cycle.
  - After address N-1 is written, return to IDLE.
- IDLE + `flip_req`: go to FLIP_WAIT. On a synchronised rising edge of `vblank`, toggle `front_page`, pulse `flip_done`, and return to IDLE.
- Simultaneous events in IDLE:
  - `we` alongside `clear_start` or `flip_req`: the write is performed.
  - `clear_start` and `flip_req` together: the clear wins and the flip is discarded.
- `clear_start` or `flip_req` outside IDLE: ignored.
- Read side:
  - `front_page` passes through a 2-FF synchroniser into `rd_clk`.
  - With `re` high: `palette_index <= mem[{front_rd, RESOLUTION_X*pxl_y + pxl_x}]`.
  - Out-of-range read coordinates return 0. With `re` low, the output is 0.
- Reset mid-CLEAR or mid-FLIP_WAIT aborts the operation: state IDLE, `front_page = 0`, no done pulse.

## Timing
- Reset values: `palette_index = 0`, `wr_ready = 1`, `flip_done = 0`, `clear_busy = 0`, `front_page = 0`. `palette_index` clears on the `rd_clk` edges seen while `reset` is high.
- Read latency: 1 `rd_clk` cycle from `re`/coordinates to `palette_index`.
- Write latency: 1 `wr_clk` cycle, accepted on the edge where `we && wr_ready`.
- Clear: `clear_busy` rises the cycle after `clear_start` and stays high exactly N cycles. `wr_ready` is low for those N cycles.
- Flip:
  - `vblank` goes through a 2-FF sync plus an edge detect. `front_page` toggles on the 3rd `wr_clk` edge after `vblank` rises.
  - `flip_done` is high in that same cycle.
  - `front_rd` follows 2 `rd_clk` edges later, still within vblank.
- A `vblank` edge that occurs while not in FLIP_WAIT is discarded. A flip is never applied at a later vblank.

## Configuration
- `FRAMEBUFFER_CLEAR_EN` defined: the CLEAR state, fill counter and fill latch are present, as described above.
- `FRAMEBUFFER_CLEAR_EN` undefined:
  - `clear_start` and `fill_index` are ignored.
  - `clear_busy` is tied to 0 and the FSM has only IDLE and FLIP_WAIT.
  - `clear_start` + `flip_req` together: the flip is taken.

## Test plan
- Write / read: write (5,7)=0x3C, flip, wait vblank → read (5,7) returns 0x3C one `rd_clk` after `re`. With `re=0` the read returns 0.
- Out of range: write (400,0)=0xFF → memory unchanged. Read (0,300) → 0.
- Clear: `clear_start` with `fill_index=0x11` → `clear_busy` high 120000 cycles, `wr_ready` low throughout. After the flip, sampled pixels (0,0), (399,299) and (200,150) all read 0x11.
- Flip gating: `flip_req` with no vblank for 1000 cycles → `front_page` stays 0 and writes are stalled. Raise `vblank` → `flip_done` on the 3rd `wr_clk` edge and `front_page=1`.
- Collisions: `clear_start` and `flip_req` in the same cycle → CLEAR entered, no `flip_done` at the next vblank. `we` in the same cycle is still written.
- Reset mid-clear: assert `reset` at clear cycle 500 → `clear_busy=0`, `wr_ready=1`, `front_page=0`, `palette_index=0`, no `flip_done`.

Source files
------------

// File: rtl/framebuffer_dbuf.sv
// Double-buffered palette-index framebuffer: the rasteriser draws the back page on wr_clk while scan-out reads the front page on rd_clk.
// Latency: writes land 1 wr_clk after acceptance; reads return 1 rd_clk after re; a requested flip lands on the 3rd wr_clk edge after vblank rises.
// Backpressure: wr_ready is low while a fill runs or a flip waits for vblank; writes offered then are held off, not dropped.
//
// Ports
//   wr_clk, reset                 write/control clock; synchronous active-high reset, also sampled on rd_clk
//   rd_clk, re, pxl_x, pxl_y      scan-out read request
//   vblank                        level-high vertical blank from the scan-out side
//   palette_index                 registered front-page pixel (rd_clk)
//   we, wr_ready, wr_pxl_x/y,
//   wr_palette_index              back-page write port (accepted when we && wr_ready)
//   flip_req, flip_done           page-swap request and its completion pulse
//   clear_start, fill_index,
//   clear_busy                    back-page fill engine (present only with FRAMEBUFFER_CLEAR_EN)
//   front_page                    current front page, wr_clk domain
//
// Build option: define FRAMEBUFFER_CLEAR_EN to include the fill engine (CLEAR state, counter, fill latch).

module framebuffer_dbuf #(
    parameter int RESOLUTION_X   = 400,
    parameter int RESOLUTION_Y   = 300,
    parameter int PALETTE_LENGTH = 256,
    localparam int PW = $clog2(PALETTE_LENGTH),
    localparam int XW = $clog2(RESOLUTION_X),
    localparam int YW = $clog2(RESOLUTION_Y),
    localparam int N  = RESOLUTION_X * RESOLUTION_Y,
    localparam int AW = $clog2(N)
) (
    input  logic          wr_clk,
    input  logic          reset,
    input  logic          rd_clk,
    input  logic          re,
    input  logic [XW-1:0] pxl_x,
    input  logic [YW-1:0] pxl_y,
    input  logic          vblank,
    output logic [PW-1:0] palette_index,
    input  logic          we,
    output logic          wr_ready,
    input  logic [XW-1:0] wr_pxl_x,
    input  logic [YW-1:0] wr_pxl_y,
    input  logic [PW-1:0] wr_palette_index,
    input  logic          flip_req,
    output logic          flip_done,
    input  logic          clear_start,
    input  logic [PW-1:0] fill_index,
    output logic          clear_busy,
    output logic          front_page
);

    // Range limits carry one extra bit so a power-of-two resolution still compares correctly.
    localparam logic [XW:0]   X_LIM  = (XW+1)'(RESOLUTION_X);
    localparam logic [YW:0]   Y_LIM  = (YW+1)'(RESOLUTION_Y);
    localparam logic [AW-1:0] X_MUL  = AW'(RESOLUTION_X);
    localparam logic [AW-1:0] LAST_A = AW'(N - 1);

`ifdef FRAMEBUFFER_CLEAR_EN
    typedef enum logic [1:0] {ST_IDLE, ST_FLIP_WAIT, ST_CLEAR} state_t;
`else
    typedef enum logic [0:0] {ST_IDLE, ST_FLIP_WAIT} state_t;
`endif

    // Address is {page, linear}; the top page bit selects which half is front.
    logic [PW-1:0] mem [0:(2**(AW+1))-1];

    state_t        state_q, state_d;
    logic          front_q, front_d;
    logic          flip_done_q, flip_done_d;
    logic          vb_s1_q, vb_s2_q, vb_s3_q;
    logic          vb_rise;

    logic          mem_we;
    logic [AW:0]   mem_waddr;
    logic [PW-1:0] mem_wdat;

    logic          wr_in_range;
    logic [AW-1:0] wr_lin;

    logic          front_s1_q, front_rd_q;
    logic          rd_in_range;
    logic [AW-1:0] rd_lin;
    logic [PW-1:0] palette_q;

`ifdef FRAMEBUFFER_CLEAR_EN
    logic [AW-1:0] fill_cnt_q, fill_cnt_d;
    logic [PW-1:0] fill_val_q, fill_val_d;
`else
    logic unused_clear;
    assign unused_clear = ^{clear_start, fill_index};
`endif

    assign wr_in_range = ({1'b0, wr_pxl_x} < X_LIM) && ({1'b0, wr_pxl_y} < Y_LIM);
    assign wr_lin      = X_MUL * AW'(wr_pxl_y) + AW'(wr_pxl_x);
    assign rd_in_range = ({1'b0, pxl_x} < X_LIM) && ({1'b0, pxl_y} < Y_LIM);
    assign rd_lin      = X_MUL * AW'(pxl_y) + AW'(pxl_x);

    // Only a rise seen while already waiting counts; stale rises are simply not looked at.
    assign vb_rise = vb_s2_q & ~vb_s3_q;

    always_comb begin
        state_d     = state_q;
        front_d     = front_q;
        flip_done_d = 1'b0;
        mem_we      = 1'b0;
        mem_waddr   = {~front_q, wr_lin};
        mem_wdat    = wr_palette_index;
`ifdef FRAMEBUFFER_CLEAR_EN
        fill_cnt_d  = fill_cnt_q;
        fill_val_d  = fill_val_q;
`endif
        case (state_q)
            ST_IDLE: begin
                // A write offered alongside a clear/flip request is still taken.
                mem_we = we && wr_in_range;
`ifdef FRAMEBUFFER_CLEAR_EN
                if (clear_start) begin
                    // Clear has priority; a simultaneous flip request is dropped.
                    state_d    = ST_CLEAR;
                    fill_cnt_d = '0;
                    fill_val_d = fill_index;
                end else if (flip_req) begin
                    state_d = ST_FLIP_WAIT;
                end
`else
                if (flip_req) begin
                    state_d = ST_FLIP_WAIT;
                end
`endif
            end
            ST_FLIP_WAIT: begin
                if (vb_rise) begin
                    front_d     = ~front_q;
                    flip_done_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
`ifdef FRAMEBUFFER_CLEAR_EN
            ST_CLEAR: begin
                mem_we     = 1'b1;
                mem_waddr  = {~front_q, fill_cnt_q};
                mem_wdat   = fill_val_q;
                fill_cnt_d = fill_cnt_q + 1'b1;
                if (fill_cnt_q == LAST_A) begin
                    state_d = ST_IDLE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge wr_clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            front_q     <= 1'b0;
            flip_done_q <= 1'b0;
            vb_s1_q     <= 1'b0;
            vb_s2_q     <= 1'b0;
            vb_s3_q     <= 1'b0;
`ifdef FRAMEBUFFER_CLEAR_EN
            fill_cnt_q  <= '0;
            fill_val_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            front_q     <= front_d;
            flip_done_q <= flip_done_d;
            vb_s1_q     <= vblank;
            vb_s2_q     <= vb_s1_q;
            vb_s3_q     <= vb_s2_q;
`ifdef FRAMEBUFFER_CLEAR_EN
            fill_cnt_q  <= fill_cnt_d;
            fill_val_q  <= fill_val_d;
`endif
        end
    end

    // Pixel storage is deliberately not reset.
    always_ff @(posedge wr_clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdat;
        end
    end

    // Read side: reset is held long enough to be seen on several rd_clk edges.
    always_ff @(posedge rd_clk) begin
        if (reset) begin
            front_s1_q <= 1'b0;
            front_rd_q <= 1'b0;
            palette_q  <= '0;
        end else begin
            front_s1_q <= front_q;
            front_rd_q <= front_s1_q;
            if (re && rd_in_range) begin
                palette_q <= mem[{front_rd_q, rd_lin}];
            end else begin
                palette_q <= '0;
            end
        end
    end

    assign palette_index = palette_q;
    assign wr_ready      = (state_q == ST_IDLE);
    assign flip_done     = flip_done_q;
    assign front_page    = front_q;
`ifdef FRAMEBUFFER_CLEAR_EN
    assign clear_busy    = (state_q == ST_CLEAR);
`else
    assign clear_busy    = 1'b0;
`endif

endmodule

// File: tb/tb_framebuffer_dbuf.sv
module tb_framebuffer_dbuf;

    localparam int RX = 40;
    localparam int RY = 30;
    localparam int NP = RX * RY;

    logic       wr_clk = 1'b0;
    logic       rd_clk = 1'b0;
    logic       reset = 1'b1;
    logic       re = 1'b0;
    logic [5:0] pxl_x = '0;
    logic [4:0] pxl_y = '0;
    logic       vblank = 1'b0;
    logic [7:0] palette_index;
    logic       we = 1'b0;
    logic       wr_ready;
    logic [5:0] wr_pxl_x = '0;
    logic [4:0] wr_pxl_y = '0;
    logic [7:0] wr_palette_index = '0;
    logic       flip_req = 1'b0;
    logic       flip_done;
    logic       clear_start = 1'b0;
    logic [7:0] fill_index = '0;
    logic       clear_busy;
    logic       front_page;

    int n_tests = 0;
    int n_fail  = 0;
    int flip_cnt = 0;

    framebuffer_dbuf #(
        .RESOLUTION_X(RX), .RESOLUTION_Y(RY), .PALETTE_LENGTH(256)
    ) dut (
        .wr_clk(wr_clk), .reset(reset), .rd_clk(rd_clk), .re(re),
        .pxl_x(pxl_x), .pxl_y(pxl_y), .vblank(vblank), .palette_index(palette_index),
        .we(we), .wr_ready(wr_ready), .wr_pxl_x(wr_pxl_x), .wr_pxl_y(wr_pxl_y),
        .wr_palette_index(wr_palette_index), .flip_req(flip_req), .flip_done(flip_done),
        .clear_start(clear_start), .fill_index(fill_index), .clear_busy(clear_busy),
        .front_page(front_page)
    );

    always #5 wr_clk = ~wr_clk;
    always #7 rd_clk = ~rd_clk;

    always @(posedge wr_clk) begin
        if (flip_done === 1'b1) flip_cnt <= flip_cnt + 1;
    end

    typedef struct {
        logic [5:0] wx;
        logic [4:0] wy;
        logic [7:0] wd;
        logic [5:0] rx;
        logic [4:0] ry;
        logic       rre;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wr_tick();
        @(posedge wr_clk);
        #1;
    endtask

    task automatic rd_tick();
        @(posedge rd_clk);
        #1;
    endtask

    task automatic rd_check(input logic [5:0] x, input logic [4:0] y, input logic r,
                            input logic [7:0] exp, input string name);
        rd_tick();
        re = r; pxl_x = x; pxl_y = y;
        rd_tick();
        chk(name, palette_index, exp);
        re = 1'b0;
    endtask

    task automatic flip_request();
        flip_req = 1'b1;
        wr_tick();
        flip_req = 1'b0;
        repeat (3) wr_tick();
    endtask

    // Raise vblank right after a wr_clk edge; the swap must show after the 3rd edge.
    task automatic vblank_flip(input logic exp_front, input string name);
        vblank = 1'b1;
        wr_tick();
        wr_tick();
        chk({name, "_early"}, flip_done, 1'b0);
        wr_tick();
        chk({name, "_done"}, flip_done, 1'b1);
        chk({name, "_front"}, front_page, exp_front);
        wr_tick();
        vblank = 1'b0;
        repeat (4) wr_tick();
        repeat (5) rd_tick();
    endtask

    task automatic vblank_idle();
        vblank = 1'b1;
        repeat (6) wr_tick();
        vblank = 1'b0;
        repeat (4) wr_tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic bad;
        int   f0;
        int   cnt;

        vecs[0]  = '{6'd5,  5'd7,  8'h3C, 6'd5,  5'd7,  1'b1, 8'h3C};
        vecs[1]  = '{6'd0,  5'd0,  8'hA5, 6'd0,  5'd0,  1'b1, 8'hA5};
        vecs[2]  = '{6'd39, 5'd29, 8'h5A, 6'd39, 5'd29, 1'b1, 8'h5A};
        vecs[3]  = '{6'd0,  5'd1,  8'h12, 6'd0,  5'd1,  1'b1, 8'h12};
        vecs[4]  = '{6'd40, 5'd0,  8'hFF, 6'd0,  5'd1,  1'b1, 8'h12}; // dropped; would alias (0,1)
        vecs[5]  = '{6'd2,  5'd0,  8'h66, 6'd5,  5'd7,  1'b0, 8'h00}; // re low reads 0
        vecs[6]  = '{6'd0,  5'd30, 8'h99, 6'd0,  5'd30, 1'b1, 8'h00};
        vecs[7]  = '{6'd10, 5'd10, 8'hC3, 6'd2,  5'd0,  1'b1, 8'h66};
        vecs[8]  = '{6'd1,  5'd0,  8'h0F, 6'd10, 5'd10, 1'b1, 8'hC3};
        vecs[9]  = '{6'd63, 5'd31, 8'hEE, 6'd63, 5'd0,  1'b1, 8'h00};
        vecs[10] = '{6'd1,  5'd0,  8'hF0, 6'd1,  5'd0,  1'b1, 8'hF0};

        // Reset
        repeat (8) wr_tick();
        chk("rst_palette", palette_index, 8'h00);
        reset = 1'b0;
        wr_tick();
        chk("rst_wr_ready", wr_ready, 1'b1);
        chk("rst_flip_done", flip_done, 1'b0);
        chk("rst_clear_busy", clear_busy, 1'b0);
        chk("rst_front", front_page, 1'b0);

        // Fill the back page (page 1) from the table
        for (int i = 0; i < 11; i++) begin
            we = 1'b1;
            wr_pxl_x = vecs[i].wx; wr_pxl_y = vecs[i].wy; wr_palette_index = vecs[i].wd;
            wr_tick();
        end
        we = 1'b0;

        // Flip gating: no vblank for 1000 cycles; offered write must stall
        flip_req = 1'b1;
        wr_tick();
        flip_req = 1'b0;
        we = 1'b1; wr_pxl_x = 6'd5; wr_pxl_y = 5'd7; wr_palette_index = 8'hEE;
        bad = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (front_page !== 1'b0 || wr_ready !== 1'b0 || flip_done !== 1'b0) bad = 1'b1;
            wr_tick();
        end
        chk("flip_gated", bad, 1'b0);
        we = 1'b0;
        vblank_flip(1'b1, "flip1");
        chk("flip1_ready", wr_ready, 1'b1);
        chk("flip1_pulse", flip_cnt, 1);

        for (int i = 0; i < 11; i++) begin
            rd_check(vecs[i].rx, vecs[i].ry, vecs[i].rre, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // vblank with no pending flip is ignored
        f0 = flip_cnt;
        vblank_idle();
        chk("stray_vblank_cnt", flip_cnt, f0);
        chk("stray_vblank_front", front_page, 1'b1);

`ifdef FRAMEBUFFER_CLEAR_EN
        // Collision: clear + flip + write together; clear wins
        clear_start = 1'b1; flip_req = 1'b1; fill_index = 8'h11;
        we = 1'b1; wr_pxl_x = 6'd8; wr_pxl_y = 5'd8; wr_palette_index = 8'h44;
        wr_tick();
        clear_start = 1'b0; flip_req = 1'b0; we = 1'b0;
        chk("clr_busy_rise", clear_busy, 1'b1);
        cnt = 0; bad = 1'b0;
        for (int i = 0; i < NP + 20 && clear_busy === 1'b1; i++) begin
            cnt++;
            if (wr_ready !== 1'b0) bad = 1'b1;
            wr_tick();
        end
        chk("clr_busy_len", cnt, NP);
        chk("clr_ready_low", bad, 1'b0);
        chk("clr_ready_back", wr_ready, 1'b1);
        f0 = flip_cnt;
        vblank_idle();
        chk("clr_flip_dropped", flip_cnt, f0);
        flip_request();
        vblank_flip(1'b0, "flip2");
        rd_check(6'd0, 5'd0, 1'b1, 8'h11, "fill_0_0");
        rd_check(6'd39, 5'd29, 1'b1, 8'h11, "fill_39_29");
        rd_check(6'd20, 5'd15, 1'b1, 8'h11, "fill_20_15");

        // Reset mid-clear, with a write alongside clear_start
        re = 1'b1; pxl_x = 6'd0; pxl_y = 5'd0;
        repeat (3) rd_tick();
        chk("pre_reset_read", palette_index, 8'h11);
        clear_start = 1'b1; fill_index = 8'h22;
        we = 1'b1; wr_pxl_x = 6'd39; wr_pxl_y = 5'd29; wr_palette_index = 8'h44;
        wr_tick();
        clear_start = 1'b0; we = 1'b0;
        repeat (499) wr_tick();
        chk("mid_clear_busy", clear_busy, 1'b1);
        f0 = flip_cnt;
        reset = 1'b1;
        repeat (8) wr_tick();
        chk("rst_mid_palette", palette_index, 8'h00);
        chk("rst_mid_busy", clear_busy, 1'b0);
        chk("rst_mid_ready", wr_ready, 1'b1);
        chk("rst_mid_front", front_page, 1'b0);
        re = 1'b0;
        reset = 1'b0;
        wr_tick();
        vblank_idle();
        chk("rst_mid_no_flip", flip_cnt, f0);
        flip_request();
        vblank_flip(1'b1, "flip3");
        rd_check(6'd39, 5'd29, 1'b1, 8'h44, "clr_side_write");
        rd_check(6'd10, 5'd10, 1'b1, 8'h22, "part_fill_10_10");
        rd_check(6'd1, 5'd0, 1'b1, 8'h22, "part_fill_1_0");
`else
        // Collision without fill engine: flip is taken, write still performed
        clear_start = 1'b1; flip_req = 1'b1; fill_index = 8'h11;
        we = 1'b1; wr_pxl_x = 6'd8; wr_pxl_y = 5'd8; wr_palette_index = 8'h44;
        wr_tick();
        clear_start = 1'b0; flip_req = 1'b0; we = 1'b0;
        chk("clr_disabled_busy", clear_busy, 1'b0);
        chk("collide_flip_wait", wr_ready, 1'b0);
        vblank_flip(1'b0, "flip2");
        rd_check(6'd8, 5'd8, 1'b1, 8'h44, "collide_write");

        // Back to page 1 as front, then reset in the middle of a flip wait
        flip_request();
        vblank_flip(1'b1, "flip3");
        re = 1'b1; pxl_x = 6'd5; pxl_y = 5'd7;
        repeat (3) rd_tick();
        chk("pre_reset_read", palette_index, 8'h3C);
        flip_request();
        repeat (500) wr_tick();
        chk("mid_wait_ready", wr_ready, 1'b0);
        f0 = flip_cnt;
        reset = 1'b1;
        repeat (8) wr_tick();
        chk("rst_mid_palette", palette_index, 8'h00);
        chk("rst_mid_busy", clear_busy, 1'b0);
        chk("rst_mid_ready", wr_ready, 1'b1);
        chk("rst_mid_front", front_page, 1'b0);
        re = 1'b0;
        reset = 1'b0;
        wr_tick();
        vblank_idle();
        chk("rst_mid_no_flip", flip_cnt, f0);
        chk("rst_mid_front_after", front_page, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
